// File: rtl/azimuth_pattern_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : azimuth_gen_pkg
// Brief    : Shared state encoding and index-width helper for the azimuth
//            pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
package azimuth_gen_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/azimuth_pattern_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : azimuth_pattern_generator_if
// Brief    : Control/pattern inputs and serial outputs of the azimuth
//            pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
interface azimuth_pattern_generator_if
    import azimuth_gen_pkg::*;
#(
    parameter int SIZE      = 3200,
    parameter int CHANNELS  = 2,
    parameter int DIV_WIDTH = 16,
    parameter int IDX_W     = idx_width(SIZE)
);

    logic                       en;
    logic                       trig;
    logic                       mode;
    logic [DIV_WIDTH-1:0]       div;
    logic                       load;
    logic [CHANNELS*SIZE-1:0]   load_data;
    logic [CHANNELS-1:0]        gen_signal;
    logic                       busy;
    logic [IDX_W-1:0]           bit_idx;
    logic                       sweep_done;
    logic                       overrun;

    modport master (
        output en, trig, mode, div, load, load_data,
        input  gen_signal, busy, bit_idx, sweep_done, overrun
    );

    modport slave (
        input  en, trig, mode, div, load, load_data,
        output gen_signal, busy, bit_idx, sweep_done, overrun
    );

endinterface
`default_nettype wire

// File: rtl/azimuth_pattern_generator_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : azimuth_prescaler
// Brief    : Bit-period down-counter; tick marks the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module azimuth_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 load,
    input  wire logic                 run,
    input  wire logic [DIV_WIDTH-1:0] period,
    output logic                      tick
);

    logic [DIV_WIDTH-1:0] r_period;
    logic [DIV_WIDTH-1:0] r_cnt;

    // The period is captured only on load so mid-sweep divider changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_period <= period;
            r_cnt    <= period;
        end else if (run) begin
            r_cnt <= (r_cnt == '0) ? r_period : r_cnt - 1'b1;
        end
    end

    assign tick = run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/azimuth_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : azimuth_pattern_generator
// Brief    : Double-buffered multi-channel serial pattern generator with
//            one-shot / continuous sweeps and registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module azimuth_pattern_generator
    import azimuth_gen_pkg::*;
#(
    parameter int SIZE      = 3200,
    parameter int CHANNELS  = 2,
    parameter int DIV_WIDTH = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    azimuth_pattern_generator_if.slave bus
);

    localparam int                 c_idx_w    = idx_width(SIZE);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(SIZE - 1);

    logic [0:0]                         r_state;
    logic [0:0]                         w_state_nxt;
    logic [c_idx_w-1:0]                 r_idx;
    logic [c_idx_w-1:0]                 w_idx_nxt;
    logic [CHANNELS-1:0][SIZE-1:0]      r_active;
    logic [CHANNELS-1:0][SIZE-1:0]      r_shadow;
    logic [CHANNELS-1:0][SIZE-1:0]      w_active_nxt;
    logic                               r_pending;
    logic                               r_trig_q;
    logic [CHANNELS-1:0]                r_gen;
    logic [CHANNELS-1:0]                w_gen_nxt;
    logic                               r_busy;
    logic [c_idx_w-1:0]                 r_bit_idx;
    logic                               r_done;
    logic                               r_overrun;
    logic                               w_run;
    logic                               w_trig_ev;
    logic                               w_tick;
    logic                               w_last;
    logic                               w_start;

    assign w_run     = (r_state == ST_RUN);
    assign w_trig_ev = bus.trig & ~r_trig_q;
    assign w_last    = w_run & w_tick & (r_idx == c_last_idx);
    assign w_start   = (~w_run & bus.en & w_trig_ev) | (w_last & bus.en & bus.mode);

    azimuth_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .load   (w_start),
        .run    (w_run),
        .period (bus.div),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!w_run) begin
            w_state_nxt = w_start ? ST_RUN : ST_IDLE;
        end else if (!bus.en) begin
            w_state_nxt = ST_IDLE;
        end else if (w_last) begin
            w_state_nxt = bus.mode ? ST_RUN : ST_IDLE;
        end
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_start || (w_state_nxt == ST_IDLE)) begin
            w_idx_nxt = '0;
        end else if (w_tick) begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    // Swap reads the shadow before any same-cycle LOAD overwrites it.
    assign w_active_nxt = (w_start && r_pending) ? r_shadow : r_active;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_gen_nxt[c] = w_active_nxt[c][w_idx_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_trig_q  <= 1'b0;
            r_gen     <= '0;
            r_busy    <= 1'b0;
            r_bit_idx <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_active  <= w_active_nxt;
            if (bus.load) begin
                r_shadow <= bus.load_data;
            end
            r_pending <= bus.load | (r_pending & ~w_start);
            r_trig_q  <= bus.trig;
            r_gen     <= (w_state_nxt == ST_RUN) ? w_gen_nxt : '0;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_bit_idx <= (w_state_nxt == ST_RUN) ? w_idx_nxt : '0;
            r_done    <= w_last & bus.en;
            r_overrun <= w_run & w_trig_ev;
        end
    end

    assign bus.gen_signal = r_gen;
    assign bus.busy       = r_busy;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.sweep_done = r_done;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_azimuth_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_azimuth_pattern_generator
// Brief    : Directed bench with a sweep-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_azimuth_pattern_generator;

    localparam int SIZE      = 16;
    localparam int CHANNELS  = 2;
    localparam int DIV_WIDTH = 16;
    localparam int IDX_W     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    azimuth_pattern_generator_if #(
        .SIZE (SIZE), .CHANNELS (CHANNELS), .DIV_WIDTH (DIV_WIDTH)
    ) bus ();

    azimuth_pattern_generator #(
        .SIZE (SIZE), .CHANNELS (CHANNELS), .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Sweep-level model: elapsed cycles since start, bit = elapsed / (div+1).
    logic [CHANNELS-1:0][SIZE-1:0] m_active  = '0;
    logic [CHANNELS-1:0][SIZE-1:0] m_shadow  = '0;
    bit m_pending = 1'b0;
    bit m_trig_q  = 1'b0;
    bit m_busy    = 1'b0;
    bit m_done    = 1'b0;
    bit m_ovr     = 1'b0;
    int m_elapsed = 0;
    int m_div     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        bus.trig = 1'b1;
        tick();
        bus.trig = 1'b0;
    endtask

    function automatic void m_start();
        if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        m_div     = int'(bus.div);
        m_elapsed = 0;
        m_busy    = 1'b1;
    endfunction

    always @(posedge clk) begin : p_model
        bit ev;
        if (rst) begin
            m_active = '0; m_shadow = '0; m_pending = 1'b0; m_trig_q = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_elapsed = 0;
        end else begin
            ev     = bus.trig && !m_trig_q;
            m_done = 1'b0;
            m_ovr  = 1'b0;
            if (m_busy) begin
                m_ovr = ev;
                if (!bus.en) begin
                    m_busy = 1'b0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == SIZE * (m_div + 1)) begin
                        m_done = 1'b1;
                        if (bus.mode) m_start();
                        else          m_busy = 1'b0;
                    end
                end
            end else if (bus.en && ev) begin
                m_start();
            end
            if (bus.load) begin
                m_shadow  = bus.load_data;
                m_pending = 1'b1;
            end
            m_trig_q = bus.trig;
        end
    end

    always @(negedge clk) begin : p_cmp
        logic [CHANNELS-1:0] eg;
        int b;
        if (cmp_en) begin
            b = m_busy ? m_elapsed / (m_div + 1) : 0;
            for (int c = 0; c < CHANNELS; c++)
                eg[c] = m_busy ? m_active[c][b[IDX_W-1:0]] : 1'b0;
            check("gen_signal", 64'(bus.gen_signal), 64'(eg));
            check("busy",       64'(bus.busy),       64'(m_busy));
            check("bit_idx",    64'(bus.bit_idx),    64'(b[IDX_W-1:0]));
            check("sweep_done", 64'(bus.sweep_done), 64'(m_done));
            check("overrun",    64'(bus.overrun),    64'(m_ovr));
        end
    end

    initial begin
        bus.en = 1'b0; bus.trig = 1'b0; bus.mode = 1'b0; bus.div = '0;
        bus.load = 1'b0; bus.load_data = '0;

        // Reset
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_gen",  64'(bus.gen_signal), 64'd0);
        check("rst_busy", 64'(bus.busy),       64'd0);
        check("rst_done", 64'(bus.sweep_done), 64'd0);
        rst = 1'b0;
        tick();

        // One-shot, DIV=0
        bus.en = 1'b1; bus.mode = 1'b0; bus.div = '0;
        bus.load_data = {16'hAAAA, 16'h00FF};
        bus.load = 1'b1; tick(); bus.load = 1'b0;
        pulse_trig();
        check("t1_bit0_gen", 64'(bus.gen_signal), 64'h1);
        check("t1_bit0_busy", 64'(bus.busy), 64'd1);
        for (int i = 1; i < SIZE; i++) begin
            tick();
            check("t1_ch0", 64'(bus.gen_signal[0]), 64'(i < 8));
            check("t1_ch1", 64'(bus.gen_signal[1]), 64'(i % 2));
        end
        tick();
        check("t1_done", 64'(bus.sweep_done), 64'd1);
        check("t1_idle", 64'(bus.busy), 64'd0);

        // Divider, change of DIV mid-sweep ignored
        bus.div = 16'd3;
        pulse_trig();
        repeat (10) tick();
        bus.div = '0;
        repeat (10) tick();
        check("t2_bit_idx", 64'(bus.bit_idx), 64'd5);
        repeat (43) tick();
        check("t2_still_busy", 64'(bus.busy), 64'd1);
        tick();
        check("t2_done", 64'(bus.sweep_done), 64'd1);
        check("t2_idle", 64'(bus.busy), 64'd0);

        // Continuous with mid-sweep load
        bus.mode = 1'b1;
        pulse_trig();
        repeat (4) tick();
        bus.load_data = {16'h0F0F, 16'h1234};
        bus.load = 1'b1; tick(); bus.load = 1'b0;
        repeat (11) tick();
        check("t3_done1", 64'(bus.sweep_done), 64'd1);
        check("t3_nogap", 64'(bus.busy), 64'd1);
        check("t3_newpat", 64'(bus.gen_signal), 64'h2);
        repeat (16) tick();
        check("t3_done2", 64'(bus.sweep_done), 64'd1);
        bus.mode = 1'b0;
        repeat (16) tick();
        check("t3_done3", 64'(bus.sweep_done), 64'd1);
        check("t3_idle", 64'(bus.busy), 64'd0);

        // Overrun at bit 5 and at the final bit
        pulse_trig();
        repeat (5) tick();
        pulse_trig();
        check("t4_ovr1", 64'(bus.overrun), 64'd1);
        repeat (9) tick();
        pulse_trig();
        check("t4_ovr2", 64'(bus.overrun), 64'd1);
        check("t4_done", 64'(bus.sweep_done), 64'd1);
        repeat (3) tick();
        check("t4_norestart", 64'(bus.busy), 64'd0);

        // Abort at bit 7
        pulse_trig();
        repeat (7) tick();
        bus.en = 1'b0;
        tick();
        check("t5_abort_busy", 64'(bus.busy), 64'd0);
        check("t5_abort_gen", 64'(bus.gen_signal), 64'd0);
        tick();
        check("t5_no_done", 64'(bus.sweep_done), 64'd0);
        bus.en = 1'b1;
        tick();

        // Reset mid-sweep clears buffers
        pulse_trig();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        tick();
        pulse_trig();
        check("t5_cleared_busy", 64'(bus.busy), 64'd1);
        check("t5_cleared_gen", 64'(bus.gen_signal), 64'd0);
        repeat (16) tick();
        check("t5_cleared_done", 64'(bus.sweep_done), 64'd1);

        // LOAD coincident with trigger
        bus.load_data = {16'hC3C3, 16'h5A5A};
        bus.load = 1'b1; tick();
        bus.load_data = {16'h1111, 16'hF0F0};
        bus.trig = 1'b1;
        tick();
        bus.load = 1'b0; bus.trig = 1'b0;
        check("t6_a_bit0", 64'(bus.gen_signal), 64'h2);
        tick();
        check("t6_a_bit1", 64'(bus.gen_signal), 64'h3);
        repeat (3) tick();
        check("t6_a_bit4", 64'(bus.gen_signal), 64'h1);
        repeat (12) tick();
        check("t6_a_done", 64'(bus.sweep_done), 64'd1);
        pulse_trig();
        repeat (4) tick();
        check("t6_b_bit4", 64'(bus.gen_signal), 64'h3);
        repeat (14) tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/azimuth_pattern_generator.md
# azimuth_pattern_generator

Multi-channel, double-buffered successor to the single-channel azimuth signal generator. On a trigger it serialises a SIZE-bit pattern per channel onto GEN_SIGNAL, bit 0 first, holding each bit for a programmable number of clocks. It runs in one-shot or continuous mode, and a shadow buffer lets software stage the next pattern without tearing a sweep in progress. It sits between the AXI pattern registers and the radar azimuth/ACP output pins.

## Interface
- SIZE, 3200: bits per sweep per channel.
- CHANNELS, 2: independent output channels, all sharing one bit counter.
- DIV_WIDTH, 16: width of the bit-period divider.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- EN  in  1  enable. Low forces abort and idle.
- TRIG  in  1  start request. Synchronous to CLK; acts on its rising edge.
- MODE  in  1  0 = one-shot, 1 = continuous re-sweep.
- DIV  in  DIV_WIDTH  bit period minus 1, in CLK cycles. Latched at each sweep start.
- LOAD  in  1  one-cycle strobe that writes LOAD_DATA into the shadow buffer.
- LOAD_DATA  in  CHANNELS*SIZE  pattern. Channel c, bit i = LOAD_DATA[c*SIZE+i].
- GEN_SIGNAL  out  CHANNELS  serial pattern outputs.
- BUSY  out  1  high while a sweep is running.
- BIT_IDX  out  $clog2(SIZE)  index of the bit currently driven.
- SWEEP_DONE  out  1  one-cycle pulse when a sweep completes normally.
- OVERRUN  out  1  one-cycle pulse when a trigger edge arrives while BUSY.

## Operation
- Buffers and flag:
  - Active buffer: drives the outputs.
  - Shadow buffer: staging area written by LOAD.
  - `pending` flag: set by LOAD.
- Trigger event: TRIG=1 and TRIG_q=0, where TRIG_q is TRIG registered one cycle.
- Sweep start, occurring on a trigger event from IDLE with EN=1, or on a continuous restart:
  - If `pending` is set: active <= shadow and `pending` clears.
  - DIV is latched.
  - Bit index and prescaler clear.
- LOAD:
  - shadow <= LOAD_DATA and `pending` <= 1, in any state.
  - LOAD in the same cycle as a sweep start: the swap uses the old shadow, the new data is written to shadow, and `pending` stays 1. New data applies only from the next sweep start.
- States:
  - IDLE -> RUN on a trigger event with EN=1.
  - RUN -> RUN when the last bit period ends with MODE=1 and EN=1. Restart with no gap and pulse SWEEP_DONE.
  - RUN -> IDLE when the last bit period ends with MODE=0. Pulse SWEEP_DONE.
  - RUN -> IDLE on EN=0 (abort). No SWEEP_DONE.
  - IDLE holds while EN=0 or there is no trigger event.
- A trigger event during RUN is ignored and pulses OVERRUN; the sweep is unaffected.
- In IDLE: GEN_SIGNAL=0 and BIT_IDX=0.
- MODE is sampled only at the end of a sweep.
- Changing DIV mid-sweep has no effect until the next sweep start.

## Timing
- Reset: all outputs 0, both buffers 0, `pending`=0, TRIG_q=0, state IDLE. RST has priority over all other inputs, including mid-sweep.
- Trigger event sampled at edge t:
  - BUSY=1 and GEN_SIGNAL=bit 0 in cycle t+1.
  - Bit i is driven in cycles t+1+i*(DIV+1) through t+(i+1)*(DIV+1).
- One sweep lasts exactly SIZE*(DIV+1) cycles.
- SWEEP_DONE is high in the first cycle after the last bit. That cycle is bit 0 of the next sweep in continuous mode, or the first IDLE cycle (BUSY=0) otherwise.
- Abort: EN sampled low at edge t gives GEN_SIGNAL=0 and BUSY=0 from cycle t+1.
- A trigger edge coinciding with the final bit cycle counts as OVERRUN and does not start a new sweep.
- All outputs are registered; there is no combinational path from input to output.
- Prescaler counts DIV down to 0, then advances BIT_IDX. BIT_IDX wraps from SIZE-1 to 0 only on a restart.

## Structure
- Package azimuth_gen_pkg holds:
  - State encoding localparams: ST_IDLE, ST_RUN.
  - Helper function for the index width.
- Sub-module azimuth_prescaler (DIV_WIDTH-bit down-counter):
  - Inputs: load, period.
  - Output: `tick` on the last cycle of each bit period.
- Top level holds: FSM, buffers, bit counter, output mux and pulse generation.

## Test plan
- Basic one-shot, SIZE=16, CHANNELS=2, DIV=0, ch0=0x00FF, ch1=0xAAAA, LOAD then trigger -> ch0 high for 8 cycles then low for 8; ch1 alternates starting at 0; SWEEP_DONE at t+17; BUSY low at t+17.
- Divider, DIV=3 -> each bit held 4 cycles; sweep is 64 cycles; DIV changed to 0 mid-sweep has no effect.
- Continuous, MODE=1, LOAD of a new pattern mid-sweep -> current sweep unchanged; next sweep uses the new pattern with no gap cycle; SWEEP_DONE pulses every 16 cycles.
- Overrun, second TRIG edge at bit 5 and another at the final bit -> OVERRUN pulses twice; output sequence unchanged; no restart in one-shot mode.
- Abort and reset, EN=0 at bit 7 -> GEN_SIGNAL=0 and BUSY=0 the next cycle, no SWEEP_DONE. Separately, RST at bit 3 -> all outputs 0 and buffers cleared.
- LOAD coincident with trigger, shadow previously pending with A, LOAD of B on the trigger cycle -> sweep plays A; next trigger plays B.
